// File: rtl/platform_seq.sv
// platform_seq: layer sequencer for the build platform.
// For each layer it raises the platform, runs one print pass, waits on the
// platform (dwell), lowers the platform, and then counts the layer.
//
// Parameter
//   TIMEOUT_CYC   maximum number of dwell cycles in PLAT while waiting for
//                 PtoDownEn (default 48000, which is 500 us at 96 MHz)
// Ports
//   clk, rst      system clock and synchronous active-high reset
//   start         starts one layer; accepted only in IDLE
//   abort         returns to IDLE from any state
//   up_done       platform raise has completed
//   print_done    print pass has completed
//   PtoDownEn     permission to lower the platform
//   down_done     platform lower has completed
//   st_req_up     one-cycle request strobe: raise
//   st_req_print  one-cycle request strobe: print
//   st_req_down   one-cycle request strobe: lower
//   st_platform   high for the whole platform dwell
//   busy          high when the sequencer is not idle
//   layer_done    one-cycle strobe when a layer completes
//   err           sticky dwell-timeout flag; cleared by an accepted start
//   layer_cnt     count of completed layers (wraps from 0xFFFF to 0x0000)
module platform_seq #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd48000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        up_done,
  input  logic        print_done,
  input  logic        PtoDownEn,
  input  logic        down_done,
  output logic        st_req_up,
  output logic        st_req_print,
  output logic        st_req_down,
  output logic        st_platform,
  output logic        busy,
  output logic        layer_done,
  output logic        err,
  output logic [15:0] layer_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ_UP,
    S_UP,
    S_REQ_PRINT,
    S_PRINT,
    S_PLAT,
    S_REQ_DOWN,
    S_DOWN,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] dwell;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dwell     <= '0;
      err       <= 1'b0;
      layer_cnt <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_REQ_UP;
            err   <= 1'b0;
          end
        end
        S_REQ_UP:    state <= S_UP;
        S_UP:        if (up_done) state <= S_REQ_PRINT;
        S_REQ_PRINT: state <= S_PRINT;
        S_PRINT: begin
          if (print_done) begin
            state <= S_PLAT;
            dwell <= '0;
          end
        end
        S_PLAT: begin
          dwell <= dwell + 16'd1;
          // A lower permission that arrives on the timeout cycle still wins.
          if (PtoDownEn) begin
            state <= S_REQ_DOWN;
          end else if (dwell == TIMEOUT_CYC - 16'd1) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end
        end
        S_REQ_DOWN:  state <= S_DOWN;
        S_DOWN: begin
          if (down_done) begin
            state     <= S_DONE;
            layer_cnt <= layer_cnt + 16'd1;
          end
        end
        S_DONE:      state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // The status outputs are decoded from the state register only.
  always_comb begin
    st_req_up    = (state == S_REQ_UP);
    st_req_print = (state == S_REQ_PRINT);
    st_req_down  = (state == S_REQ_DOWN);
    st_platform  = (state == S_PLAT);
    layer_done   = (state == S_DONE);
    busy         = (state != S_IDLE);
  end

endmodule

// File: tb/tb_platform_seq.sv
module tb_platform_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort, up_done, print_done, PtoDownEn, down_done;
  logic        st_req_up, st_req_print, st_req_down, st_platform;
  logic        busy, layer_done, err;
  logic [15:0] layer_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  int cnt_up = 0, cnt_pr = 0, cnt_dn = 0, cnt_plat = 0, cnt_done = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  platform_seq #(.TIMEOUT_CYC(16'd16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .up_done      (up_done),
    .print_done   (print_done),
    .PtoDownEn    (PtoDownEn),
    .down_done    (down_done),
    .st_req_up    (st_req_up),
    .st_req_print (st_req_print),
    .st_req_down  (st_req_down),
    .st_platform  (st_platform),
    .busy         (busy),
    .layer_done   (layer_done),
    .err          (err),
    .layer_cnt    (layer_cnt)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: strobe/level counts and layer_cnt at each layer_done.
  always @(negedge clk) begin
    if (st_req_up)    cnt_up++;
    if (st_req_print) cnt_pr++;
    if (st_req_down)  cnt_dn++;
    if (st_platform)  cnt_plat++;
    if (layer_done) begin
      cnt_done++;
      obs_q.push_back(layer_cnt);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // Bit order: st_req_up, st_req_print, st_req_down, st_platform, busy, layer_done, err
  function automatic logic [6:0] outs();
    return {st_req_up, st_req_print, st_req_down, st_platform, busy, layer_done, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a layer with raise/print completions held, ending in PLAT.
  task automatic to_plat();
    start = 1'b1; up_done = 1'b1; print_done = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    up_done = 1'b0; print_done = 1'b0;
  endtask

  int b_up, b_pr, b_dn, b_plat, b_done;
  int n;
  logic [15:0] exp_cnt;
  logic [15:0] e, o;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; up_done = 1'b0;
    print_done = 1'b0; PtoDownEn = 1'b0; down_done = 1'b0;
    exp_cnt = '0;

    // Reset state
    cyc(2);
    chk("reset_outs", outs(), 7'b0000000);
    chk("reset_cnt", layer_cnt, 16'h0000);
    rst = 1'b0;
    cyc(1);

    // Nominal layer with delayed completions
    b_up = cnt_up; b_pr = cnt_pr; b_dn = cnt_dn; b_plat = cnt_plat; b_done = cnt_done;
    start = 1'b1;
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back(exp_cnt);
    cyc(1);
    start = 1'b0;
    chk("nom_req_up", outs(), 7'b1000100);
    cyc(1);
    chk("nom_up", outs(), 7'b0000100);
    cyc(2);
    up_done = 1'b1; cyc(1); up_done = 1'b0;
    chk("nom_req_print", outs(), 7'b0100100);
    cyc(3);
    print_done = 1'b1; cyc(1); print_done = 1'b0;
    chk("nom_plat", outs(), 7'b0001100);
    cyc(5);
    PtoDownEn = 1'b1; cyc(1); PtoDownEn = 1'b0;
    chk("nom_req_down", outs(), 7'b0010100);
    cyc(3);
    down_done = 1'b1; cyc(1); down_done = 1'b0;
    chk("nom_done", outs(), 7'b0000110);
    chk("nom_cnt", layer_cnt, 16'd1);
    cyc(1);
    chk("nom_idle", outs(), 7'b0000000);
    chk("nom_n_up", cnt_up - b_up, 1);
    chk("nom_n_print", cnt_pr - b_pr, 1);
    chk("nom_n_down", cnt_dn - b_dn, 1);
    chk("nom_n_plat", cnt_plat - b_plat, 6);
    chk("nom_n_done", cnt_done - b_done, 1);

    // Dwell timeout
    b_dn = cnt_dn; b_plat = cnt_plat;
    to_plat();
    chk("to_plat", outs(), 7'b0001100);
    cyc(15);
    chk("to_plat_last", outs(), 7'b0001100);
    cyc(1);
    chk("to_idle_err", outs(), 7'b0000001);
    chk("to_n_plat", cnt_plat - b_plat, 16);
    chk("to_n_down", cnt_dn - b_dn, 0);
    chk("to_cnt", layer_cnt, exp_cnt);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("abort_keeps_err", outs(), 7'b0000001);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("start_clears_err", outs(), 7'b1000100);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("abort_req_up", outs(), 7'b0000000);

    // Permission on the exact timeout cycle
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back(exp_cnt);
    to_plat();
    cyc(15);
    PtoDownEn = 1'b1; cyc(1); PtoDownEn = 1'b0;
    chk("edge_req_down", outs(), 7'b0010100);
    down_done = 1'b1; cyc(2); down_done = 1'b0;
    chk("edge_done", outs(), 7'b0000110);
    chk("edge_cnt", layer_cnt, exp_cnt);
    cyc(1);

    // abort with start in IDLE, then abort during PRINT
    abort = 1'b1; start = 1'b1; cyc(1); abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", outs(), 7'b0000000);
    b_plat = cnt_plat;
    start = 1'b1; up_done = 1'b1; cyc(1); start = 1'b0;
    cyc(3); up_done = 1'b0;
    chk("ab_print", outs(), 7'b0000100);
    abort = 1'b1; print_done = 1'b1; cyc(1); abort = 1'b0; print_done = 1'b0;
    chk("ab_idle", outs(), 7'b0000000);
    cyc(2);
    chk("ab_n_plat", cnt_plat - b_plat, 0);
    chk("ab_cnt", layer_cnt, exp_cnt);

    // Early completions: up_done held before start, print_done only in REQ_PRINT
    up_done = 1'b1; cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    chk("early_up", outs(), 7'b0000100);
    cyc(1); up_done = 1'b0;
    chk("early_req_print", outs(), 7'b0100100);
    print_done = 1'b1; cyc(1); print_done = 1'b0;
    cyc(3);
    chk("early_print_wait", outs(), 7'b0000100);
    abort = 1'b1; cyc(1); abort = 1'b0;

    // Minimum layer time with everything held high
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back(exp_cnt);
    up_done = 1'b1; print_done = 1'b1; PtoDownEn = 1'b1; down_done = 1'b1;
    start = 1'b1; cyc(1); start = 1'b0;
    n = 1;
    while (busy && n < 30) begin
      cyc(1);
      n++;
    end
    chk("min_layer_cycles", n, 9);
    chk("min_layer_cnt", layer_cnt, exp_cnt);

    // Reset mid-DOWN overrides abort/start
    down_done = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(6);
    chk("rst_in_down", outs(), 7'b0000100);
    b_up = cnt_up; b_pr = cnt_pr; b_dn = cnt_dn; b_done = cnt_done;
    rst = 1'b1; abort = 1'b1; start = 1'b1; down_done = 1'b1;
    cyc(1);
    rst = 1'b0; abort = 1'b0; start = 1'b0; down_done = 1'b0;
    up_done = 1'b0; print_done = 1'b0; PtoDownEn = 1'b0;
    chk("rst_outs", outs(), 7'b0000000);
    chk("rst_cnt", layer_cnt, 16'h0000);
    cyc(4);
    chk("rst_quiet", (cnt_up - b_up) + (cnt_pr - b_pr) + (cnt_dn - b_dn) + (cnt_done - b_done), 0);
    chk("rst_idle", outs(), 7'b0000000);

    // Counter wrap from 0xFFFF
    force dut.layer_cnt = 16'hFFFF;
    #1;
    release dut.layer_cnt;
    cyc(1);
    chk("wrap_preload", layer_cnt, 16'hFFFF);
    exp_cnt = 16'h0000;
    exp_q.push_back(exp_cnt);
    up_done = 1'b1; print_done = 1'b1; PtoDownEn = 1'b1; down_done = 1'b1;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(8);
    up_done = 1'b0; print_done = 1'b0; PtoDownEn = 1'b0; down_done = 1'b0;
    chk("wrap_idle", outs(), 7'b0000000);
    chk("wrap_cnt", layer_cnt, 16'h0000);

    // Scoreboard: layer_cnt observed at each layer_done
    cyc(1);
    chk("sb_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("sb_layer_cnt", o, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
